uart_rx: RTL and testbench

//  UART receiver, N,8,1, LSB first; receive counterpart of the uart_tx transmitter on the same serial link.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 36 +++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receiver and transmitter. It holds the
//   frame-FSM state encoding (3-bit) and the number of data bits per frame.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop metastability synchroniser for a single asynchronous input.
//   RESET_VAL sets the value both flops take on reset. For a UART line this
//   is 1, which matches the idle level of the line.
// Ports
//   i_Clock  in  1  destination clock
//   i_Reset  in  1  asynchronous, active-high reset
//   i_D      in  1  asynchronous input
//   o_Q      out 1  synchronised output, two clocks of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_D,
  output logic o_Q
);

  logic r_meta;
  logic r_sync;

  // The first flop may go metastable. The second flop gives it a full
  // clock period to settle before the value is used.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   UART receiver for 8 data bits, no parity and 1 stop bit, sent LSB first.
//   The serial line is oversampled on i_Clock. Each bit is sampled at its
//   centre, and the assembled byte is presented with a one-clock valid strobe.
//   The block applies no back-pressure, so the consumer must take o_RX_Byte
//   while o_RX_DV is high.
// Parameters
//   CLKS_PER_BIT  i_Clock cycles per bit, equal to f(i_Clock)/baud. The
//                 minimum is 4.
// Ports
//   i_Clock         in  1  system clock
//   i_Reset         in  1  asynchronous, active-high reset
//   i_RX_Serial     in  1  asynchronous serial line, idle high
//   o_RX_DV         out 1  one-clock strobe that marks o_RX_Byte as newly valid
//   o_RX_Byte       out 8  last received byte, held until the next strobe
//   o_RX_Active     out 1  high from the accepted start bit until the stop sample
//   o_RX_Frame_Err  out 1  one-clock strobe, set when the stop bit is sampled low
// Build option
//   UART_RX_FRAME_CHECK_EN: when defined, o_RX_Frame_Err reports a low stop
//   bit. When undefined, o_RX_Frame_Err is tied to 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
  localparam logic [CW-1:0] TERM_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t    r_state, w_next_state;
  logic [CW-1:0]  r_count, w_next_count;
  logic [IW-1:0]  r_idx,   w_next_idx;
  logic [7:0]     r_shift, w_next_shift;
  logic [7:0]     r_byte,  w_next_byte;
  logic           r_dv,    w_next_dv;
  logic           r_active, w_next_active;
  logic           w_rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_D     (i_RX_Serial),
    .o_Q     (w_rx_s)
  );

`ifdef UART_RX_FRAME_CHECK_EN
  logic r_ferr, w_next_ferr;
`endif

  // Frame FSM next-state and datapath logic.
  // START waits half a bit, so each later terminal count falls at a bit
  // centre. A start bit that is no longer low at that point is treated as
  // a glitch.
  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_idx    = r_idx;
    w_next_shift  = r_shift;
    w_next_byte   = r_byte;
    w_next_dv     = 1'b0;
    w_next_active = r_active;
`ifdef UART_RX_FRAME_CHECK_EN
    w_next_ferr   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_next_count = '0;
        w_next_idx   = '0;
        if (!w_rx_s) w_next_state = START;
      end
      START: begin
        if (r_count == HALF_CNT) begin
          w_next_count = '0;
          if (!w_rx_s) begin
            w_next_active = 1'b1;
            w_next_state  = DATA;
          end else begin
            w_next_state  = IDLE;
          end
        end else begin
          w_next_count = r_count + CW'(1);
        end
      end
      DATA: begin
        if (r_count == TERM_CNT) begin
          w_next_count        = '0;
          w_next_shift[r_idx] = w_rx_s;
          if (r_idx < LAST_IDX) begin
            w_next_idx = r_idx + IW'(1);
          end else begin
            w_next_idx   = '0;
            w_next_state = STOP;
          end
        end else begin
          w_next_count = r_count + CW'(1);
        end
      end
      STOP: begin
        // The byte is delivered whatever level the stop bit has.
        if (r_count == TERM_CNT) begin
          w_next_count  = '0;
          w_next_byte   = r_shift;
          w_next_dv     = 1'b1;
          w_next_active = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
          w_next_ferr   = ~w_rx_s;
`endif
          w_next_state  = CLEANUP;
        end else begin
          w_next_count = r_count + CW'(1);
        end
      end
      CLEANUP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any frame in progress and
  // clears the held byte.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_dv     <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_idx    <= w_next_idx;
      r_shift  <= w_next_shift;
      r_byte   <= w_next_byte;
      r_dv     <= w_next_dv;
      r_active <= w_next_active;
    end
  end

`ifdef UART_RX_FRAME_CHECK_EN
  // Frame-error strobe register. It is set in the same cycle as DV.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_ferr <= 1'b0;
    else         r_ferr <= w_next_ferr;
  end
  assign o_RX_Frame_Err = r_ferr;
`else
  assign o_RX_Frame_Err = 1'b0;
`endif

  assign o_RX_DV     = r_dv;
  assign o_RX_Byte   = r_byte;
  assign o_RX_Active = r_active;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Testbench for uart_rx. It drives two receivers:
//   - rx8 runs at 8 clocks per bit, for function and timing tests.
//   - rx217 runs at 217 clocks per bit, for baud-skew tolerance.
//   A bench-side transmitter pushes each expected {frame error, byte} onto a
//   queue. The monitors pop the queue on every DV and compare.
module tb_uart_rx;

  localparam int CPB      = 8;
  localparam int HALF     = (CPB - 1) / 2;
  localparam int CPB_SLOW = 217;
`ifdef UART_RX_FRAME_CHECK_EN
  localparam logic FERR_ON = 1'b1;
`else
  localparam logic FERR_ON = 1'b0;
`endif

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       rxLine8   = 1'b1;
  logic       rxLine217 = 1'b1;
  logic       dv8, active8, ferr8;
  logic [7:0] byte8;
  logic       dv217, active217, ferr217;
  logic [7:0] byte217;

  logic [8:0] expQ8[$];
  logic [8:0] expQ217[$];
  logic [8:0] exp8, exp217;

  int   totalChecks = 0;
  int   badChecks   = 0;
  int   cycleCount  = 0;
  int   dvCount8    = 0;
  int   dvCount217  = 0;
  int   lastDvCycle8 = 0;
  int   dvBefore;
  int   startEdge;
  logic prevDv8 = 1'b0, prevActive8 = 1'b0, prevDv217 = 1'b0;
  logic dvActive8 = 1'b0, dvActivePrev8 = 1'b0;

  always #5 clock = ~clock;

  // Counts posedges so that DV timing can be measured in clocks.
  always @(posedge clock) cycleCount++;

  uart_rx #(.CLKS_PER_BIT(CPB)) rx8 (
    .i_Clock        (clock),
    .i_Reset        (reset),
    .i_RX_Serial    (rxLine8),
    .o_RX_DV        (dv8),
    .o_RX_Byte      (byte8),
    .o_RX_Active    (active8),
    .o_RX_Frame_Err (ferr8)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_SLOW)) rx217 (
    .i_Clock        (clock),
    .i_Reset        (reset),
    .i_RX_Serial    (rxLine217),
    .o_RX_DV        (dv217),
    .o_RX_Byte      (byte217),
    .o_RX_Active    (active217),
    .o_RX_Frame_Err (ferr217)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Bench-side transmitter. It sends one frame (start, 8 data bits LSB
  // first, stop) on the selected line, and it returns at the end of the
  // stop bit with the line idle.
  task automatic applyStimulus(input int lineSel, input logic [7:0] data,
                               input logic stopBit, input int bitClks,
                               input bit pushExp);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    if (pushExp) begin
      if (lineSel == 0) expQ8.push_back({~stopBit & FERR_ON, data});
      else              expQ217.push_back({~stopBit & FERR_ON, data});
    end
    for (int i = 0; i < 10; i++) begin
      if (lineSel == 0) rxLine8 = frame[i];
      else              rxLine217 = frame[i];
      repeat (bitClks) @(negedge clock);
    end
    if (lineSel == 0) rxLine8 = 1'b1;
    else              rxLine217 = 1'b1;
  endtask

  // Monitor for rx8. It pops the scoreboard on DV and checks the strobe
  // width, the frame-error pairing, and Active around DV.
  always @(negedge clock) begin
    if (dv8) begin
      dvCount8++;
      lastDvCycle8  = cycleCount;
      dvActive8     = active8;
      dvActivePrev8 = prevActive8;
      checkOutput("dvWidth8", {31'd0, prevDv8}, 0);
      if (expQ8.size() == 0) begin
        checkOutput("unexpectedDv8", {31'd0, dv8}, 0);
      end else begin
        exp8 = expQ8.pop_front();
        checkOutput("rxByte8", {24'd0, byte8}, {24'd0, exp8[7:0]});
        checkOutput("frameErr8", {31'd0, ferr8}, {31'd0, exp8[8]});
      end
    end
    if (ferr8) checkOutput("ferrStrobe8", {31'd0, dv8}, 1);
    prevDv8     = dv8;
    prevActive8 = active8;
  end

  // Monitor for rx217.
  always @(negedge clock) begin
    if (dv217) begin
      dvCount217++;
      checkOutput("dvWidth217", {31'd0, prevDv217}, 0);
      if (expQ217.size() == 0) begin
        checkOutput("unexpectedDv217", {31'd0, dv217}, 0);
      end else begin
        exp217 = expQ217.pop_front();
        checkOutput("rxByte217", {24'd0, byte217}, {24'd0, exp217[7:0]});
        checkOutput("frameErr217", {31'd0, ferr217}, {31'd0, exp217[8]});
      end
    end
    prevDv217 = dv217;
  end

  // Watchdog that stops the run if the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("resetDv", {31'd0, dv8}, 0);
    checkOutput("resetByte", {24'd0, byte8}, 0);
    checkOutput("resetActive", {31'd0, active8}, 0);
    checkOutput("resetFerr", {31'd0, ferr8}, 0);
    checkOutput("resetByte217", {24'd0, byte217}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Receive a byte, then confirm that it is held after DV.
    applyStimulus(0, 8'h81, 1'b1, CPB, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("byteHeld", {24'd0, byte8}, 32'h81);

    // Reset in the middle of a partial frame.
    dvBefore = dvCount8;
    rxLine8 = 1'b0; repeat (CPB) @(negedge clock);
    rxLine8 = 1'b0; repeat (CPB) @(negedge clock);
    rxLine8 = 1'b1; repeat (CPB) @(negedge clock);
    rxLine8 = 1'b0; repeat (CPB / 2) @(negedge clock);
    checkOutput("activeMidFrame", {31'd0, active8}, 1);
    reset = 1'b1; rxLine8 = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("abortByte", {24'd0, byte8}, 0);
    checkOutput("abortActive", {31'd0, active8}, 0);
    checkOutput("abortDv", {31'd0, dv8}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // Send 0xA5 and check the DV latency measured from the start edge.
    // The next posedge is the first one that samples the low line.
    startEdge = cycleCount + 1;
    applyStimulus(0, 8'hA5, 1'b1, CPB, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("dvCountA5", dvCount8 - dvBefore, 1);
    checkOutput("dvLatency", lastDvCycle8 - startEdge, 3 + HALF + 9 * CPB);
    checkOutput("activeAtDv", {31'd0, dvActive8}, 0);
    checkOutput("activeBeforeDv", {31'd0, dvActivePrev8}, 1);

    // Three frames sent back-to-back with no idle gap.
    dvBefore = dvCount8;
    applyStimulus(0, 8'h00, 1'b1, CPB, 1'b1);
    applyStimulus(0, 8'hFF, 1'b1, CPB, 1'b1);
    applyStimulus(0, 8'h55, 1'b1, CPB, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("dvCountB2B", dvCount8 - dvBefore, 3);

    // A glitch shorter than half a bit must be rejected.
    dvBefore = dvCount8;
    rxLine8 = 1'b0; repeat (3) @(negedge clock);
    rxLine8 = 1'b1; repeat (3 * CPB) @(negedge clock);
    checkOutput("glitchDv", dvCount8 - dvBefore, 0);
    checkOutput("glitchActive", {31'd0, active8}, 0);
    checkOutput("glitchByte", {24'd0, byte8}, 32'h55);

    // Stop bit forced low. The byte is still delivered, and the receiver
    // then recovers for the next frame.
    dvBefore = dvCount8;
    applyStimulus(0, 8'h3C, 1'b0, CPB, 1'b1);
    repeat (3 * CPB) @(negedge clock);
    checkOutput("badStopDv", dvCount8 - dvBefore, 1);
    applyStimulus(0, 8'h96, 1'b1, CPB, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("recoverDv", dvCount8 - dvBefore, 2);

    // Baud skew of +/-2% at 217 clocks per bit.
    applyStimulus(1, 8'h41, 1'b1, 221, 1'b1);
    repeat (CPB_SLOW) @(negedge clock);
    applyStimulus(1, 8'h41, 1'b1, 213, 1'b1);
    repeat (CPB_SLOW) @(negedge clock);
    checkOutput("skewDvCount", dvCount217, 2);

    for (int i = 0; i < 1000 && (expQ8.size() != 0 || expQ217.size() != 0); i++)
      @(negedge clock);
    checkOutput("pendingExp8", expQ8.size(), 0);
    checkOutput("pendingExp217", expQ217.size(), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
